// File: rtl/sb_pkg.sv
// Shared scoreboard parameters and helpers: register-count derivation and popcount.
// Pure constants and functions, no timing or back-pressure of its own.
package sb_pkg;

    localparam int ADDR_W_DEF   = 3;
    localparam bit ZERO_REG_DEF = 1'b1;
    localparam int MAX_REGS     = 256;

    function automatic int num_regs(input int aw);
        return 1 << aw;
    endfunction

    // Fixed-width argument; callers zero-extend narrower vectors.
    function automatic int popcount(input logic [MAX_REGS-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bundle between decode, scoreboard and register file.
// Issue handshake is iss_en/iss_ack; writeback has no back-pressure.
interface reg_scoreboard_if
    import sb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    localparam int NUM_REGS = num_regs(ADDR_W);

    logic                iss_en;
    logic                iss_wr;
    logic [ADDR_W-1:0]   iss_rd;
    logic [ADDR_W-1:0]   iss_rs;
    logic [ADDR_W-1:0]   iss_rt;
    logic                iss_ack;
    logic                stall;
    logic                wb_en;
    logic [ADDR_W-1:0]   wb_addr;
    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] busy;
    logic [ADDR_W:0]     busy_cnt;
    logic                full;
    logic                wb_err;

    modport master (
        output iss_en, iss_wr, iss_rd, iss_rs, iss_rt, wb_en, wb_addr,
        input  iss_ack, stall, wr_sel, busy, busy_cnt, full, wb_err
    );

    modport slave (
        input  iss_en, iss_wr, iss_rd, iss_rs, iss_rt, wb_en, wb_addr,
        output iss_ack, stall, wr_sel, busy, busy_cnt, full, wb_err
    );

endinterface

// File: rtl/decoder_onehot.sv
// Address to one-hot decoder with enable; all zeros when disabled.
// Purely combinational, zero latency, no back-pressure.
module decoder_onehot
    import sb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic                     i_en,
    output logic [(1<<ADDR_W)-1:0]   o_y
);

    always_comb begin
        o_y = '0;
        if (i_en) o_y[i_addr] = 1'b1;
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: combinational RAW/WAW stall with same-cycle writeback bypass,
// busy/wr_sel/busy_cnt registered (1 cycle); writeback is always consumed, issue waits on stall.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = ZERO_REG_DEF
) (
    input  logic             clk,
    input  logic             reset,
    reg_scoreboard_if.slave  sb
);

    localparam int NUM_REGS = num_regs(ADDR_W);
    localparam int CNT_W    = ADDR_W + 1;

    // Register 0 is excluded from tracking when it is hardwired to zero.
    localparam logic [NUM_REGS-1:0] REG_MASK = ZERO_REG ? {{(NUM_REGS-1){1'b1}}, 1'b0}
                                                        : {NUM_REGS{1'b1}};
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(ZERO_REG ? NUM_REGS - 1 : NUM_REGS);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] r_wr_sel;
    logic [CNT_W-1:0]    r_busy_cnt;
    logic                r_wb_err;

    logic [NUM_REGS-1:0] w_set_raw;
    logic [NUM_REGS-1:0] w_set_oh;
    logic [NUM_REGS-1:0] w_wb_oh;
    logic [NUM_REGS-1:0] w_hz_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_stall;
    logic                w_ack;
    logic                w_set_en;
    logic                w_wb_miss;

    decoder_onehot #(.ADDR_W(ADDR_W)) u_dec_iss (
        .i_addr (sb.iss_rd),
        .i_en   (w_set_en),
        .o_y    (w_set_raw)
    );

    decoder_onehot #(.ADDR_W(ADDR_W)) u_dec_wb (
        .i_addr (sb.wb_addr),
        .i_en   (sb.wb_en),
        .o_y    (w_wb_oh)
    );

    // A register retiring this cycle no longer blocks its consumers.
    assign w_hz_busy = r_busy & ~w_wb_oh;

    assign w_stall   = sb.iss_en & (w_hz_busy[sb.iss_rs] | w_hz_busy[sb.iss_rt] |
                                    (sb.iss_wr & w_hz_busy[sb.iss_rd]));
    assign w_ack     = sb.iss_en & ~w_stall;
    assign w_set_en  = w_ack & sb.iss_wr;
    assign w_set_oh  = w_set_raw & REG_MASK;

    // Set is OR-ed after the clear so a same-address set/clear leaves the bit set.
    assign w_busy_nxt = w_hz_busy | w_set_oh;
    assign w_wb_miss  = sb.wb_en & ~r_busy[sb.wb_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy     <= '0;
            r_wr_sel   <= '0;
            r_busy_cnt <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_wr_sel   <= w_wb_oh & REG_MASK;
            r_busy_cnt <= CNT_W'(popcount(MAX_REGS'(w_busy_nxt)));
            if (w_wb_miss) r_wb_err <= 1'b1;
        end
    end

    assign sb.stall    = w_stall;
    assign sb.iss_ack  = w_ack;
    assign sb.busy     = r_busy;
    assign sb.wr_sel   = r_wr_sel;
    assign sb.busy_cnt = r_busy_cnt;
    assign sb.full     = (r_busy_cnt == FULL_CNT);
    assign sb.wb_err   = r_wb_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard (ADDR_W=3, ZERO_REG=1): directed scenarios plus random
// traffic against a per-register reference model; monitors pop expected values and compare.
module tb_reg_scoreboard;

    typedef struct {
        logic stall;
        logic ack;
    } comb_t;

    typedef struct {
        logic [7:0] busy;
        logic [7:0] wr_sel;
        logic [3:0] cnt;
        logic       full;
        logic       err;
    } regs_t;

    logic clk;
    logic reset;

    reg_scoreboard_if #(.ADDR_W(3)) sb_if ();

    reg_scoreboard #(.ADDR_W(3), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    int    errors = 0;
    int    checks = 0;
    comb_t cq[$];
    regs_t rq[$];
    bit    mdl_busy[8];
    bit    mdl_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hz(input int r, input bit wben, input int wba);
        return mdl_busy[r] && !(wben && wba == r);
    endfunction

    function automatic int mdl_count();
        int c = 0;
        for (int i = 0; i < 8; i++) if (mdl_busy[i]) c++;
        return c;
    endfunction

    function automatic logic [7:0] mdl_vec();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = mdl_busy[i];
        return v;
    endfunction

    task automatic drive_idle();
        sb_if.iss_en  = 1'b0;
        sb_if.iss_wr  = 1'b0;
        sb_if.iss_rd  = '0;
        sb_if.iss_rs  = '0;
        sb_if.iss_rt  = '0;
        sb_if.wb_en   = 1'b0;
        sb_if.wb_addr = '0;
    endtask

    task automatic step(input bit en, input bit wr, input int rd, input int rs, input int rt,
                        input bit wben, input int wba);
        comb_t ce;
        regs_t re;
        @(negedge clk);
        sb_if.iss_en  = en;
        sb_if.iss_wr  = wr;
        sb_if.iss_rd  = 3'(rd);
        sb_if.iss_rs  = 3'(rs);
        sb_if.iss_rt  = 3'(rt);
        sb_if.wb_en   = wben;
        sb_if.wb_addr = 3'(wba);
        ce.stall = en && (hz(rs, wben, wba) || hz(rt, wben, wba) || (wr && hz(rd, wben, wba)));
        ce.ack   = en && !ce.stall;
        cq.push_back(ce);
        if (wben) begin
            if (!mdl_busy[wba]) mdl_err = 1'b1;
            mdl_busy[wba] = 1'b0;
        end
        if (ce.ack && wr && rd != 0) mdl_busy[rd] = 1'b1;
        re.wr_sel = (wben && wba != 0) ? 8'(1 << wba) : 8'h00;
        re.busy   = mdl_vec();
        re.cnt    = 4'(mdl_count());
        re.full   = (mdl_count() == 7);
        re.err    = mdl_err;
        rq.push_back(re);
    endtask

    task automatic push_zero_regs();
        regs_t re;
        re.busy = 8'h00; re.wr_sel = 8'h00; re.cnt = 4'd0; re.full = 1'b0; re.err = 1'b0;
        rq.push_back(re);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},   32'(sb_if.busy),     32'h0);
        chk({tag, "_cnt"},    32'(sb_if.busy_cnt), 32'h0);
        chk({tag, "_wr_sel"}, 32'(sb_if.wr_sel),   32'h0);
        chk({tag, "_full"},   32'(sb_if.full),     32'h0);
        chk({tag, "_wb_err"}, 32'(sb_if.wb_err),   32'h0);
        chk({tag, "_stall"},  32'(sb_if.stall),    32'h0);
        chk({tag, "_ack"},    32'(sb_if.iss_ack),  32'h0);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic reset_mid();
        comb_t ce;
        ce.stall = 1'b0; ce.ack = 1'b0;
        @(negedge clk);
        drive_idle();
        cq.push_back(ce);
        #2 reset = 1'b1;
        #1 check_all_zero("mid_reset");
        for (int i = 0; i < 8; i++) mdl_busy[i] = 1'b0;
        mdl_err = 1'b0;
        push_zero_regs();
        @(negedge clk);
        cq.push_back(ce);
        push_zero_regs();
        #2 reset = 1'b0;
    endtask

    // Combinational outputs checked mid-low-phase, registered ones just after the edge.
    initial begin
        comb_t e;
        forever begin
            @(negedge clk);
            #1;
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk("stall",   32'(sb_if.stall),   32'(e.stall));
                chk("iss_ack", 32'(sb_if.iss_ack), 32'(e.ack));
            end
        end
    end

    initial begin
        regs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rq.size() > 0) begin
                e = rq.pop_front();
                chk("busy",     32'(sb_if.busy),     32'(e.busy));
                chk("wr_sel",   32'(sb_if.wr_sel),   32'(e.wr_sel));
                chk("busy_cnt", 32'(sb_if.busy_cnt), 32'(e.cnt));
                chk("full",     32'(sb_if.full),     32'(e.full));
                chk("wb_err",   32'(sb_if.wb_err),   32'(e.err));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        int pick;
        int k;
        reset = 1'b1;
        drive_idle();
        mdl_err = 1'b0;
        for (int i = 0; i < 8; i++) mdl_busy[i] = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        #1 reset = 1'b0;

        // RAW stall, retire, delayed wr_sel
        step(1, 1, 5, 0, 0, 0, 0);
        step(1, 0, 0, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 5);
        step(0, 0, 0, 0, 0, 0, 0);
        // source bypass on retiring register
        step(1, 1, 3, 0, 0, 0, 0);
        step(1, 0, 0, 0, 3, 1, 3);
        // destination bypass: set wins over clear
        step(1, 1, 4, 0, 0, 0, 0);
        step(1, 1, 4, 0, 0, 1, 4);
        step(0, 0, 0, 0, 0, 1, 4);
        // register 0 never tracked, then fill 1..7
        step(1, 1, 0, 0, 0, 0, 0);
        for (int r = 1; r < 8; r++) step(1, 1, r, 0, 0, 0, 0);
        step(1, 1, 6, 0, 0, 0, 0);
        step(0, 1, 1, 2, 3, 0, 0);
        for (int r = 1; r < 8; r++) step(0, 0, 0, 0, 0, 1, r);
        // writeback to an idle register is sticky
        step(0, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // busy = 0x66 then asynchronous reset
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 0, 0);
        step(1, 1, 6, 0, 0, 0, 0);
        reset_mid();
        step(1, 1, 6, 6, 6, 0, 0);

        for (int n = 0; n < 600; n++) begin
            nb = mdl_count();
            pick = 0;
            if (nb > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, nb - 1);
                for (int i = 0; i < 8; i++) begin
                    if (mdl_busy[i]) begin
                        if (k == 0) pick = i;
                        k--;
                    end
                end
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 pick != 0, pick);
        end

        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #3;
        chk("comb_queue_drained", 32'(cq.size()), 32'd0);
        chk("regs_queue_drained", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
